ula_port_fe: RTL and testbench
==============================

# ula_port_fe

Port 0xFE write/read back-end of the Spectrum ULA. It sits directly downstream of the CPU's ULA write decode: it latches border colour, MIC and speaker bits from OUT (0xFE) cycles and synchronises the tape EAR input for IN (0xFE) bit 6. It mixes speaker, MIC and EAR into a filtered 8-bit audio level and drives the 4-bit board audio DAC through a first-order delta-sigma stage. It replaces the ad-hoc border register in the top level and feeds the video block's `border_color` input.

## Interface
Parameters:
- `FILTER_SHIFT`, default 4: IIR coefficient is 2^-FILTER_SHIFT; legal range 1..7.
- `SAMPLE_DIV`, default 8: `clk` cycles per filter update; legal range 2..256.

Ports:
- `clk`  in  1  system clock, the same clock as the CPU write decode.
- `reset`  in  1  asynchronous, active-high; clears every register.
- `io_we`  in  1  level strobe, high for the whole CPU write to an even I/O port with M1 inactive. The strobe may stay high for many cycles.
- `io_din`  in  8  CPU data out. Valid while `io_we` is high.
- `ear_in`  in  1  tape/EAR input, asynchronous to `clk`.
- `border_color`  out  3  io_din[2:0] from the last write.
- `mic`  out  1  io_din[3] from the last write.
- `speaker`  out  1  io_din[4] from the last write.
- `ear_rd`  out  1  synchronised EAR, for IN bit 6.
- `audio_level`  out  8  filtered mix level (integer part of the accumulator).
- `audio_dac`  out  4  delta-sigma output to the audio jack.

## Operation
- Write capture: a registered `io_we_d` holds the previous value of `io_we`. In a cycle where `io_we`=1 and `io_we_d`=0, the block loads `border_color`, `mic` and `speaker` from `io_din` at that clock edge. Nothing is captured again until `io_we` has dropped to 0 and risen again. Bits 7:5 are ignored.
- EAR: `ear_in` passes through a 2-flop synchroniser, and `ear_rd` is the second flop.
- Mix: `level` = (`speaker` ? 192 : 0) + (`mic` ? 32 : 0) + (`ear_rd` ? 16 : 0). This is 8-bit and at most 240, so it never overflows.
- Sample counter: `sdiv` counts 0..SAMPLE_DIV-1 and wraps. The filter updates only in a cycle where `sdiv`=SAMPLE_DIV-1.
- Filter: `acc` is 16 bits, unsigned 8.8 format.
  - `diff` = {`level`, 8'h00} − `acc`, computed as 17-bit signed.
  - `acc` <= `acc` + (`diff` >>> FILTER_SHIFT), using an arithmetic shift. The result always stays within 0..0xF000 with no clamping.
  - `audio_level` = `acc`[15:8].
- Delta-sigma: runs every `clk` cycle.
  - `sum` = `err` + `audio_level`[3:0], 5 bits.
  - `err` <= `sum`[3:0].
  - `audio_dac` <= min(15, `audio_level`[7:4] + `sum`[4]).
  - Over 16 cycles at a constant level, the count of `audio_dac` values equals the level's fractional share.
- Reset: this is the only state clearing.
  - All outputs are 0 in reset: `border_color`=0, `mic`=0, `speaker`=0, `ear_rd`=0, `audio_level`=0, `audio_dac`=0.
  - `io_we_d`, `sdiv`, `acc`, `err` and the synchroniser flops are also 0.
  - Reset asserted during a write: on release, the write is not captured if `io_we` is still high. This holds because `io_we_d` resets to 0 and would otherwise see a rising edge, so the block holds `io_we_d` at 1 for the first cycle after reset if `io_we` is 1 then.

## Timing
- `border_color`, `mic` and `speaker` change at the clock edge where the rising edge of `io_we` is sampled. They are visible 1 cycle after `io_we` first reads high.
- `ear_rd` latency is 2 `clk` edges from a stable `ear_in` change.
- The `level` change from a write reaches `acc` at the next `sdiv` wrap, which takes 1..SAMPLE_DIV cycles.
- `audio_dac` is registered, 1 cycle behind `audio_level`.
- Step response for a constant `level` L, with FILTER_SHIFT=4:
  - Each update shrinks the error by 15/16.
  - Rising to L: the truncation floor leaves `acc` ≥ L·256−15, so `audio_level` settles at L−1 or L.
  - Falling to L: `audio_level` settles at exactly L.
- A write and a filter update in the same cycle: the update uses the pre-write `level`, and the new bits apply from the next update.

## Test plan
- Reset: hold `reset` with `io_we`=1 and `io_din`=8'hFF, then release with `io_we` still 1. Required: all outputs stay 0, and no capture occurs until `io_we` is cycled 0→1.
- Edge capture: pulse `io_we` high for 5 cycles with `io_din`=8'h15. Required: `border_color`=5, `mic`=0, `speaker`=1 from cycle +1. Changing `io_din` to 8'h02 mid-pulse leaves the outputs unchanged.
- EAR sync: toggle `ear_in` 0→1. Required: `ear_rd`=1 after exactly 2 edges, and it returns to 0 two edges after `ear_in` falls.
- Filter rise/fall: write 8'h10 (speaker on, L=192). Required: after 200 updates (1600 cycles), `audio_level` ∈ {191, 192}. Then write 8'h00: `audio_level` reaches 0 and stays 0.
- Delta-sigma density: force a steady state with `audio_level`=8'h25. Required: over any 16 consecutive cycles, `audio_dac` is 3 for 5 cycles and 2 for 11 cycles, and never exceeds 15.
- Full mix: write 8'h18 with `ear_in`=1 (L=240). Required: `audio_level` ∈ {239, 240}, `audio_dac` ≤ 15, and there is no wrap of `acc`.

Source files
------------

// File: rtl/ula_port_fe.sv
// ula_port_fe: back-end of the ULA's port 0xFE.
// Latches border colour, MIC and speaker from OUT cycles, synchronises the
// tape EAR input for IN bit 6, mixes the three sound sources into a low-pass
// filtered 8-bit level and drives the 4-bit audio DAC through a first-order
// delta-sigma stage.
module ula_port_fe #(
    parameter int FILTER_SHIFT = 4,
    parameter int SAMPLE_DIV   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_we,
    input  logic [7:0] io_din,
    input  logic       ear_in,
    output logic [2:0] border_color,
    output logic       mic,
    output logic       speaker,
    output logic       ear_rd,
    output logic [7:0] audio_level,
    output logic [3:0] audio_dac
);

    localparam int SDIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SAMPLE_DIV - 1);

    // Write-strobe edge detection and the latched port bits
    logic              io_we_q, io_we_d;
    logic              armed_q, armed_d;
    logic              we_prev;
    logic              we_rise;
    logic [2:0]        border_q, border_d;
    logic              mic_q, mic_d;
    logic              spk_q, spk_d;

    // EAR synchroniser
    logic              ear_meta_q, ear_meta_d;
    logic              ear_sync_q, ear_sync_d;

    // Mixer and filter
    logic [SDIV_W-1:0] sdiv_q, sdiv_d;
    logic              sample_tick;
    logic [7:0]        level;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic [15:0]       acc_q, acc_d;

    // Delta-sigma modulator
    logic [3:0]        err_q, err_d;
    logic [4:0]        ds_sum;
    logic [4:0]        dac_wide;
    logic [3:0]        dac_q, dac_d;

    // Bits 7:5 of the port carry nothing this block uses.
    logic              unused_din;
    assign unused_din = ^io_din[7:5];

    // Capture the port bits once per write, on the first cycle the strobe is seen high.
    always_comb begin
        io_we_d  = io_we;
        armed_d  = 1'b1;
        border_d = border_q;
        mic_d    = mic_q;
        spk_d    = spk_q;
        // Until the first post-reset cycle has passed, pretend the strobe was
        // already high so a write straddling reset release is not captured.
        we_prev  = io_we_q | ~armed_q;
        we_rise  = io_we & ~we_prev;
        if (we_rise) begin
            border_d = io_din[2:0];
            mic_d    = io_din[3];
            spk_d    = io_din[4];
        end
    end

    // Two-flop synchroniser for the asynchronous tape input.
    always_comb begin
        ear_meta_d = ear_in;
        ear_sync_d = ear_meta_q;
    end

    // Sample divider, mix and one-pole IIR low-pass in 8.8 fixed point.
    always_comb begin
        sample_tick = (sdiv_q == SDIV_LAST);
        sdiv_d      = sample_tick ? '0 : (sdiv_q + SDIV_W'(1));
        level       = (spk_q      ? 8'd192 : 8'd0)
                    + (mic_q      ? 8'd32  : 8'd0)
                    + (ear_sync_q ? 8'd16  : 8'd0);
        diff        = $signed({1'b0, level, 8'h00}) - $signed({1'b0, acc_q});
        step        = diff >>> FILTER_SHIFT;
        acc_d       = acc_q;
        if (sample_tick) begin
            acc_d = 16'($signed({1'b0, acc_q}) + step);
        end
    end

    // First-order delta-sigma: the low nibble of the level dithers the high nibble.
    always_comb begin
        ds_sum   = {1'b0, err_q} + {1'b0, acc_q[11:8]};
        err_d    = ds_sum[3:0];
        dac_wide = {1'b0, acc_q[15:12]} + {4'b0000, ds_sum[4]};
        dac_d    = dac_wide[4] ? 4'hF : dac_wide[3:0];
    end

    // State registers; reset is the only thing that clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_we_q    <= 1'b0;
            armed_q    <= 1'b0;
            border_q   <= 3'd0;
            mic_q      <= 1'b0;
            spk_q      <= 1'b0;
            ear_meta_q <= 1'b0;
            ear_sync_q <= 1'b0;
            sdiv_q     <= '0;
            acc_q      <= 16'd0;
            err_q      <= 4'd0;
            dac_q      <= 4'd0;
        end else begin
            io_we_q    <= io_we_d;
            armed_q    <= armed_d;
            border_q   <= border_d;
            mic_q      <= mic_d;
            spk_q      <= spk_d;
            ear_meta_q <= ear_meta_d;
            ear_sync_q <= ear_sync_d;
            sdiv_q     <= sdiv_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            dac_q      <= dac_d;
        end
    end

    assign border_color = border_q;
    assign mic          = mic_q;
    assign speaker      = spk_q;
    assign ear_rd       = ear_sync_q;
    assign audio_level  = acc_q[15:8];
    assign audio_dac    = dac_q;

endmodule

// File: tb/tb_ula_port_fe.sv
// Testbench for ula_port_fe: directed steps with a scoreboard of expected
// values. A second instance with a long sample period holds each filter
// output for 256 cycles so the delta-sigma density can be observed.
module tb_ula_port_fe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, default parameters
    logic       reset;
    logic       io_we;
    logic [7:0] io_din;
    logic       ear_in;
    logic [2:0] border_color;
    logic       mic;
    logic       speaker;
    logic       ear_rd;
    logic [7:0] audio_level;
    logic [3:0] audio_dac;

    // Slow instance, one filter update every 256 cycles
    logic       rst_s;
    logic       we_s;
    logic [7:0] din_s;
    logic       ear_s;
    logic [2:0] border_s;
    logic       mic_s;
    logic       spk_s;
    logic       ear_rd_s;
    logic [7:0] level_s;
    logic [3:0] dac_s;

    ula_port_fe #(.FILTER_SHIFT(4), .SAMPLE_DIV(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .io_we        (io_we),
        .io_din       (io_din),
        .ear_in       (ear_in),
        .border_color (border_color),
        .mic          (mic),
        .speaker      (speaker),
        .ear_rd       (ear_rd),
        .audio_level  (audio_level),
        .audio_dac    (audio_dac)
    );

    ula_port_fe #(.FILTER_SHIFT(4), .SAMPLE_DIV(256)) u_slow (
        .clk          (clk),
        .reset        (rst_s),
        .io_we        (we_s),
        .io_din       (din_s),
        .ear_in       (ear_s),
        .border_color (border_s),
        .mic          (mic_s),
        .speaker      (spk_s),
        .ear_rd       (ear_rd_s),
        .audio_level  (level_s),
        .audio_dac    (dac_s)
    );

    typedef struct {
        string tag;
        int    lo;
        int    hi;
    } exp_t;

    exp_t sb[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the main instance's inputs.
    task automatic applyStimulus(input logic we, input logic [7:0] din, input logic ear);
        io_we  = we;
        io_din = din;
        ear_in = ear;
    endtask

    // Push an expected value (or inclusive range) onto the scoreboard.
    task automatic expectVal(input string tag, input int lo, input int hi);
        exp_t e;
        e.tag = tag;
        e.lo  = lo;
        e.hi  = hi;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare the observed value against it.
    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        logic ok;
        nCompared++;
        if (sb.size() == 0) begin
            nMismatched++;
            $error("[TB] FAIL scoreboard_empty: observed %0d, required a pending entry", observed);
        end else begin
            e  = sb.pop_front();
            ok = (e.lo == e.hi) ? (observed === 32'(e.lo))
                                : ((observed >= 32'(e.lo)) && (observed <= 32'(e.hi)));
            assert (ok === 1'b1) else begin
                nMismatched++;
                $error("[TB] FAIL %s: observed %0d, required %0d..%0d", e.tag, observed, e.lo, e.hi);
            end
        end
    endtask

    initial begin
        int cnt3;
        int cnt2;
        int lvlMin;
        int lvlMax;
        int dacMax;

        // Reset held with a write in progress and all bits set
        reset = 1'b1;
        rst_s = 1'b1;
        we_s  = 1'b0;
        din_s = 8'h00;
        ear_s = 1'b0;
        applyStimulus(1'b1, 8'hFF, 1'b0);
        tick(3);
        expectVal("rst_border", 0, 0);  checkOutput(32'(border_color));
        expectVal("rst_mic", 0, 0);     checkOutput(32'(mic));
        expectVal("rst_speaker", 0, 0); checkOutput(32'(speaker));
        expectVal("rst_ear_rd", 0, 0);  checkOutput(32'(ear_rd));
        expectVal("rst_level", 0, 0);   checkOutput(32'(audio_level));
        expectVal("rst_dac", 0, 0);     checkOutput(32'(audio_dac));

        // Release with the strobe still high: nothing may be captured
        reset = 1'b0;
        tick(3);
        expectVal("rel_border", 0, 0);  checkOutput(32'(border_color));
        expectVal("rel_mic", 0, 0);     checkOutput(32'(mic));
        expectVal("rel_speaker", 0, 0); checkOutput(32'(speaker));
        applyStimulus(1'b0, 8'hFF, 1'b0);
        tick(1);
        expectVal("rel_low_border", 0, 0); checkOutput(32'(border_color));

        // Cycling the strobe 0->1 now captures 0xFF
        applyStimulus(1'b1, 8'hFF, 1'b0);
        expectVal("cyc_pre_edge", 0, 0);  checkOutput(32'(border_color));
        tick(1);
        expectVal("cyc_border", 7, 7);  checkOutput(32'(border_color));
        expectVal("cyc_mic", 1, 1);     checkOutput(32'(mic));
        expectVal("cyc_speaker", 1, 1); checkOutput(32'(speaker));
        applyStimulus(1'b0, 8'hFF, 1'b0);
        tick(2);

        // Edge capture of 0x15, data change mid-pulse ignored
        applyStimulus(1'b1, 8'h15, 1'b0);
        expectVal("cap_pre_edge", 7, 7); checkOutput(32'(border_color));
        tick(1);
        expectVal("cap_border", 5, 5);  checkOutput(32'(border_color));
        expectVal("cap_mic", 0, 0);     checkOutput(32'(mic));
        expectVal("cap_speaker", 1, 1); checkOutput(32'(speaker));
        tick(1);
        applyStimulus(1'b1, 8'h02, 1'b0);
        tick(3);
        expectVal("hold_border", 5, 5);  checkOutput(32'(border_color));
        expectVal("hold_mic", 0, 0);     checkOutput(32'(mic));
        expectVal("hold_speaker", 1, 1); checkOutput(32'(speaker));
        applyStimulus(1'b0, 8'h02, 1'b0);
        tick(2);
        expectVal("after_border", 5, 5); checkOutput(32'(border_color));

        // EAR synchroniser latency
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick(1);
        expectVal("ear_rise_1", 0, 0); checkOutput(32'(ear_rd));
        tick(1);
        expectVal("ear_rise_2", 1, 1); checkOutput(32'(ear_rd));
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick(1);
        expectVal("ear_fall_1", 1, 1); checkOutput(32'(ear_rd));
        tick(1);
        expectVal("ear_fall_2", 0, 0); checkOutput(32'(ear_rd));

        // Filter rise to 192: truncation leaves it at 191 or 192
        applyStimulus(1'b1, 8'h10, 1'b0);
        tick(1);
        applyStimulus(1'b0, 8'h10, 1'b0);
        tick(1600);
        expectVal("rise_level", 191, 192); checkOutput(32'(audio_level));
        expectVal("rise_dac", 11, 12);     checkOutput(32'(audio_dac));

        // Filter fall to 0 settles exactly
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick(1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick(1600);
        expectVal("fall_speaker", 0, 0); checkOutput(32'(speaker));
        expectVal("fall_level", 0, 0);   checkOutput(32'(audio_level));
        expectVal("fall_dac", 0, 0);     checkOutput(32'(audio_dac));
        tick(50);
        expectVal("fall_level_hold", 0, 0); checkOutput(32'(audio_level));

        // Full mix: speaker + MIC + EAR = 240, no wrap of the accumulator
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick(3);
        applyStimulus(1'b1, 8'h18, 1'b1);
        tick(1);
        applyStimulus(1'b0, 8'h18, 1'b1);
        tick(1600);
        lvlMin = 255;
        lvlMax = 0;
        dacMax = 0;
        for (int i = 0; i < 64; i++) begin
            if (int'(audio_level) < lvlMin) lvlMin = int'(audio_level);
            if (int'(audio_level) > lvlMax) lvlMax = int'(audio_level);
            if (int'(audio_dac) > dacMax) dacMax = int'(audio_dac);
            tick(1);
        end
        expectVal("mix_mic", 1, 1);        checkOutput(32'(mic));
        expectVal("mix_ear_rd", 1, 1);     checkOutput(32'(ear_rd));
        expectVal("mix_level_min", 239, 240); checkOutput(32'(lvlMin));
        expectVal("mix_level_max", 239, 240); checkOutput(32'(lvlMax));
        expectVal("mix_dac_max", 14, 15);  checkOutput(32'(dacMax));

        // Delta-sigma density on the slow instance. With the write captured on
        // edge 2, updates land on edges 256, 512, 768, 1024 giving acc values
        // 3072, 5952, 8652, 11183 -> levels 12, 23, 33 (0x21), 43 (0x2B).
        rst_s = 1'b0;
        tick(1);
        we_s  = 1'b1;
        din_s = 8'h10;
        tick(1);
        we_s  = 1'b0;
        expectVal("slow_speaker", 1, 1); checkOutput(32'(spk_s));
        tick(798);
        expectVal("slow_level_21", 33, 33); checkOutput(32'(level_s));
        cnt3 = 0;
        cnt2 = 0;
        for (int i = 0; i < 16; i++) begin
            if (dac_s == 4'd3) cnt3++;
            if (dac_s == 4'd2) cnt2++;
            tick(1);
        end
        expectVal("dens21_count3", 1, 1);   checkOutput(32'(cnt3));
        expectVal("dens21_count2", 15, 15); checkOutput(32'(cnt2));
        tick(284);
        expectVal("slow_level_2b", 43, 43); checkOutput(32'(level_s));
        cnt3 = 0;
        cnt2 = 0;
        for (int i = 0; i < 16; i++) begin
            if (dac_s == 4'd3) cnt3++;
            if (dac_s == 4'd2) cnt2++;
            tick(1);
        end
        expectVal("dens2b_count3", 11, 11); checkOutput(32'(cnt3));
        expectVal("dens2b_count2", 5, 5);   checkOutput(32'(cnt2));

        if (sb.size() != 0) begin
            nCompared++;
            nMismatched++;
            $error("[TB] FAIL scoreboard_leftover: observed %0d entries, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
